// File: rtl/code_lock_pkg.sv
// Shared state encodings, special key codes and timer sizing for the code lock.
// Optional build macro used by the lock: CODE_LOCK_CONFIRM_EN.
package code_lock_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_UNLOCKED     = 3'd1;
  localparam logic [2:0] ST_PROG         = 3'd2;
  localparam logic [2:0] ST_PROG_CONFIRM = 3'd3;
  localparam logic [2:0] ST_LOCKOUT      = 3'd4;

  // Special keys sit just below all-ones so that digits 0..9 keep their natural codes.
  function automatic int key_set(input int dw);
    return (1 << dw) - 2;
  endfunction

  function automatic int key_cancel(input int dw);
    return (1 << dw) - 3;
  endfunction

  function automatic int timer_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad event input and lock status outputs of the code lock controller.
interface code_lock_ctrl_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 4
);
  localparam int EW = $clog2(CODE_LEN + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic               unlock;
  logic               lockout;
  logic               prog;
  logic [3:0]         fail_cnt;
  logic [EW-1:0]      entry_cnt;

  modport master (
    output key_valid, key_code,
    input  unlock, lockout, prog, fail_cnt, entry_cnt
  );

  modport slave (
    input  key_valid, key_code,
    output unlock, lockout, prog, fail_cnt, entry_cnt
  );

endinterface

// File: rtl/code_lock_timer.sv
// Loadable down-counter; expired is high during the final counted cycle.
module code_lock_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Loading N at the entry edge gives exactly N cycles before the state leaves.
  assign expired = (count == W'(1));

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: CODE_LEN-digit entry, timed unlock, failure lockout, reprogramming.
// CODE_LOCK_CONFIRM_EN: new code must be entered twice before it is stored.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int DIGIT_W        = 4,
  parameter int UNLOCK_CYCLES  = 5,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int RESET_CODE     = 0
) (
  input logic             clk,
  input logic             rst_n,
  code_lock_ctrl_if.slave bus
);

  localparam int EW = $clog2(CODE_LEN + 1);
  localparam int TW = timer_w(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam int BW = CODE_LEN * DIGIT_W;

  localparam logic [DIGIT_W-1:0] KEY_SET    = DIGIT_W'(key_set(DIGIT_W));
  localparam logic [DIGIT_W-1:0] KEY_CANCEL = DIGIT_W'(key_cancel(DIGIT_W));
  localparam logic [DIGIT_W-1:0] RST_DIGIT  = DIGIT_W'(RESET_CODE);
  localparam logic [BW-1:0]      RST_CODE   = {CODE_LEN{RST_DIGIT}};
  localparam logic [3:0]         MAX_F      = 4'(MAX_FAILS);
  localparam logic [EW-1:0]      LAST_IDX   = EW'(CODE_LEN - 1);

  logic [2:0]    state;
  logic          unlock_q;
  logic          lockout_q;
  logic          prog_q;
  logic [3:0]    fail_q;
  logic [EW-1:0] ecnt_q;
  logic [BW-1:0] entry_buf;
  logic [BW-1:0] code_q;
`ifdef CODE_LOCK_CONFIRM_EN
  logic [BW-1:0] shadow_q;
`endif

  logic          is_digit;
  logic          is_set;
  logic          is_cancel;
  logic          last_digit;
  logic [BW-1:0] next_buf;
  logic [3:0]    fail_inc;
  logic          code_match;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expired;

  assign is_digit   = bus.key_valid && (32'(bus.key_code) < 32'd10);
  assign is_set     = bus.key_valid && (bus.key_code == KEY_SET);
  assign is_cancel  = bus.key_valid && (bus.key_code == KEY_CANCEL);
  assign last_digit = (ecnt_q == LAST_IDX);
  assign next_buf   = {entry_buf[BW-DIGIT_W-1:0], bus.key_code};
  assign fail_inc   = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
  // Whole-code compare only on the final digit, so a wrong position is never revealed.
  assign code_match = (next_buf == code_q);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = TW'(UNLOCK_CYCLES);
    if (state == ST_IDLE && is_digit && last_digit) begin
      if (code_match) begin
        tmr_load = 1'b1;
      end else if (fail_inc == MAX_F) begin
        tmr_load  = 1'b1;
        tmr_value = TW'(LOCKOUT_CYCLES);
      end
    end
  end

  code_lock_timer #(
    .W(TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      prog_q    <= 1'b0;
      fail_q    <= 4'd0;
      ecnt_q    <= '0;
      entry_buf <= '0;
      code_q    <= RST_CODE;
`ifdef CODE_LOCK_CONFIRM_EN
      shadow_q  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_digit) begin
            if (last_digit) begin
              entry_buf <= '0;
              ecnt_q    <= '0;
              if (code_match) begin
                state    <= ST_UNLOCKED;
                unlock_q <= 1'b1;
                fail_q   <= 4'd0;
              end else begin
                fail_q <= fail_inc;
                if (fail_inc == MAX_F) begin
                  state     <= ST_LOCKOUT;
                  lockout_q <= 1'b1;
                end
              end
            end else begin
              entry_buf <= next_buf;
              ecnt_q    <= ecnt_q + EW'(1);
            end
          end else if (is_cancel) begin
            entry_buf <= '0;
            ecnt_q    <= '0;
          end
        end

        ST_UNLOCKED: begin
          // Expiry takes priority over a key arriving in the same cycle.
          if (tmr_expired) begin
            state    <= ST_IDLE;
            unlock_q <= 1'b0;
          end else if (is_set) begin
            state     <= ST_PROG;
            unlock_q  <= 1'b0;
            prog_q    <= 1'b1;
            entry_buf <= '0;
            ecnt_q    <= '0;
          end else if (is_cancel) begin
            state    <= ST_IDLE;
            unlock_q <= 1'b0;
          end
        end

        ST_PROG: begin
          if (is_digit) begin
            if (last_digit) begin
              entry_buf <= '0;
              ecnt_q    <= '0;
`ifdef CODE_LOCK_CONFIRM_EN
              shadow_q  <= next_buf;
              state     <= ST_PROG_CONFIRM;
`else
              code_q    <= next_buf;
              prog_q    <= 1'b0;
              state     <= ST_IDLE;
`endif
            end else begin
              entry_buf <= next_buf;
              ecnt_q    <= ecnt_q + EW'(1);
            end
          end else if (is_cancel) begin
            entry_buf <= '0;
            ecnt_q    <= '0;
            prog_q    <= 1'b0;
            state     <= ST_IDLE;
          end
        end

`ifdef CODE_LOCK_CONFIRM_EN
        ST_PROG_CONFIRM: begin
          if (is_digit) begin
            if (last_digit) begin
              entry_buf <= '0;
              ecnt_q    <= '0;
              prog_q    <= 1'b0;
              state     <= ST_IDLE;
              if (next_buf == shadow_q) begin
                code_q <= next_buf;
              end
            end else begin
              entry_buf <= next_buf;
              ecnt_q    <= ecnt_q + EW'(1);
            end
          end else if (is_cancel) begin
            entry_buf <= '0;
            ecnt_q    <= '0;
            prog_q    <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`endif

        ST_LOCKOUT: begin
          if (tmr_expired) begin
            state     <= ST_IDLE;
            lockout_q <= 1'b0;
            fail_q    <= 4'd0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          unlock_q  <= 1'b0;
          lockout_q <= 1'b0;
          prog_q    <= 1'b0;
          entry_buf <= '0;
          ecnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.lockout   = lockout_q;
  assign bus.prog      = prog_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.entry_cnt = ecnt_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: stimulus queues expected outputs per edge, a monitor checks them.
module tb_code_lock_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  string step;

  typedef struct packed {
    logic       u;
    logic       l;
    logic       p;
    logic [3:0] f;
    logic [2:0] e;
  } out_t;

  typedef struct {
    int    cyc;
    out_t  o;
    string tag;
  } exp_t;

  exp_t q[$];
  out_t prev;

  code_lock_ctrl_if #(.DIGIT_W(4), .CODE_LEN(4)) bus ();

  code_lock_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expectation due at this edge; any other output change is unexpected.
  always @(negedge clk) begin
    out_t obs;
    exp_t x;
    obs = {bus.unlock, bus.lockout, bus.prog, bus.fail_cnt, bus.entry_cnt};
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      total++;
      if (x.cyc != cyc || obs != x.o) begin
        bad++;
        $display("FAIL %s cyc=%0d got u=%0d l=%0d p=%0d f=%0d e=%0d, want u=%0d l=%0d p=%0d f=%0d e=%0d at cyc=%0d",
                 x.tag, cyc, obs.u, obs.l, obs.p, obs.f, obs.e,
                 x.o.u, x.o.l, x.o.p, x.o.f, x.o.e, x.cyc);
      end
    end else if (obs != prev) begin
      total++;
      bad++;
      $display("FAIL unexpected_change(%s) cyc=%0d got u=%0d l=%0d p=%0d f=%0d e=%0d, want u=%0d l=%0d p=%0d f=%0d e=%0d",
               step, cyc, obs.u, obs.l, obs.p, obs.f, obs.e,
               prev.u, prev.l, prev.p, prev.f, prev.e);
    end
    prev = obs;
  end

  task automatic push(input int c, input int u, input int l, input int p, input int f, input int e);
    exp_t x;
    x.cyc = c;
    x.o   = {1'(u), 1'(l), 1'(p), 4'(f), 3'(e)};
    x.tag = step;
    q.push_back(x);
  endtask

  task automatic key(input int k, input int u, input int l, input int p, input int f, input int e);
    @(negedge clk);
    #1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(k);
    push(cyc + 1, u, l, p, f, e);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  // n idle edges; the given outputs are expected from the last of them.
  task automatic nop(input int n, input int u, input int l, input int p, input int f, input int e);
    @(negedge clk);
    #1;
    push(cyc + n, u, l, p, f, e);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push(cyc + 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Four digits; entry_cnt counts 1..3 with prog/fail held, last digit gives the end state.
  task automatic code4(input int a, input int b, input int c, input int d,
                       input int p_in, input int f_in,
                       input int u_end, input int l_end, input int p_end, input int f_end);
    key(a, 0, 0, p_in, f_in, 1);
    key(b, 0, 0, p_in, f_in, 2);
    key(c, 0, 0, p_in, f_in, 3);
    key(d, u_end, l_end, p_end, f_end, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending=%0d, required completion", cyc, q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; total = 0; bad = 0;
    prev = '0;
    step = "init";
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;

    step = "reset";
    do_rst();

    step = "unlock0000";
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    nop(5, 0, 0, 0, 0, 0);

    step = "cancel";
    key(0, 0, 0, 0, 0, 1);
    key(0, 0, 0, 0, 0, 2);
    key(15, 0, 0, 0, 0, 2);
    key(14, 0, 0, 0, 0, 2);
    key(13, 0, 0, 0, 0, 0);
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    nop(5, 0, 0, 0, 0, 0);

    step = "fails";
    code4(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    key(1, 0, 0, 0, 1, 1);
    key(2, 0, 0, 0, 1, 2);
    key(13, 0, 0, 0, 1, 0);
    code4(1, 0, 0, 0, 0, 1, 0, 0, 0, 2);
    code4(1, 0, 0, 0, 0, 2, 0, 1, 0, 3);

    step = "lockout";
    repeat (4) key(0, 0, 1, 0, 3, 0);
    key(13, 0, 1, 0, 3, 0);
    nop(11, 0, 0, 0, 0, 0);
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    step = "prog";
    key(7, 1, 0, 0, 0, 0);
    key(14, 0, 0, 1, 0, 0);
`ifdef CODE_LOCK_CONFIRM_EN
    code4(3, 1, 4, 1, 1, 0, 0, 0, 1, 0);
    code4(3, 1, 4, 1, 1, 0, 0, 0, 0, 0);
`else
    code4(3, 1, 4, 1, 1, 0, 0, 0, 0, 0);
`endif

    step = "newcode";
    code4(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    code4(3, 1, 4, 1, 0, 1, 1, 0, 0, 0);
    nop(4, 1, 0, 0, 0, 0);
    step = "expiry_key";
    key(14, 0, 0, 0, 0, 0);
    nop(2, 0, 0, 0, 0, 0);

    step = "relock";
    code4(3, 1, 4, 1, 0, 0, 1, 0, 0, 0);
    key(13, 0, 0, 0, 0, 0);

    step = "prog_rst";
    code4(3, 1, 4, 1, 0, 0, 1, 0, 0, 0);
    key(14, 0, 0, 1, 0, 0);
    key(2, 0, 0, 1, 0, 1);
    key(2, 0, 0, 1, 0, 2);
    do_rst();
    step = "code_reverted";
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    nop(5, 0, 0, 0, 0, 0);

`ifdef CODE_LOCK_CONFIRM_EN
    step = "confirm_bad";
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    key(14, 0, 0, 1, 0, 0);
    code4(5, 5, 5, 5, 1, 0, 0, 0, 1, 0);
    code4(5, 5, 5, 6, 1, 0, 0, 0, 0, 0);
    code4(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step = "confirm_good";
    key(14, 0, 0, 1, 0, 0);
    code4(5, 5, 5, 5, 1, 0, 0, 0, 1, 0);
    code4(5, 5, 5, 5, 1, 0, 0, 0, 0, 0);
    code4(5, 5, 5, 5, 0, 0, 1, 0, 0, 0);
    nop(5, 0, 0, 0, 0, 0);
`endif

    step = "drain";
    nop(3, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Parametrised keypad code-lock controller; the successor of the fixed 4-digit lock. Accepts strobed key events and compares a CODE_LEN-digit entry against a stored code. Drives a timed unlock pulse, counts consecutive failures into a timed lockout, and supports reprogramming the code while unlocked. Sits between the keypad debouncer/decoder and the actuator driver.

Parameters:
CODE_LEN, 4, digits per code (2..8)
DIGIT_W, 4, bits per key code
UNLOCK_CYCLES, 5, cycles unlock stays high
MAX_FAILS, 3, consecutive wrong codes before lockout (1..15)
LOCKOUT_CYCLES, 16, cycles of lockout
RESET_CODE, 0, reset value of every stored digit

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
key_valid  in  1  one-cycle strobe: key_code valid
key_code  in  DIGIT_W  0..9 digit; all-ones-1 = SET; all-ones-2 = CANCEL; other values ignored
unlock  out  1  lock open
lockout  out  1  lockout in progress, keys ignored
prog  out  1  programming new code
fail_cnt  out  4  consecutive failures
entry_cnt  out  $clog2(CODE_LEN+1)  digits collected in current entry

Behaviour:
- Reset: synchronous active-low on rst_n; clock clk. State IDLE; all outputs 0; stored code = RESET_CODE in every digit; entry buffer and timers cleared. Reset mid-unlock/lockout/prog aborts immediately; the stored code reverts to RESET_CODE.
- Keys act only in the cycle key_valid=1. Key codes that are neither digits nor SET/CANCEL are ignored with no state change.
- IDLE/ENTRY: each digit is shifted into the entry buffer and entry_cnt increments. SET is ignored. CANCEL clears the buffer and entry_cnt, goes to IDLE, and leaves fail_cnt unchanged.
- On the CODE_LEN-th digit, compare the whole buffer in the same edge; there is no per-digit early rejection, so the position of a wrong digit is not revealed.
- Match: go to UNLOCKED, unlock=1 from the next cycle, fail_cnt=0, entry cleared.
- Mismatch: fail_cnt+1 and entry cleared. If the new fail_cnt==MAX_FAILS, go to LOCKOUT with lockout=1 from the next cycle; otherwise stay in IDLE.
- UNLOCKED: the timer loads UNLOCK_CYCLES. unlock stays high exactly UNLOCK_CYCLES cycles, then the block returns to IDLE.
  - SET before expiry: go to PROG, unlock=0, prog=1.
  - CANCEL: relock immediately.
  - Digits: ignored.
- PROG: collects CODE_LEN digits into the entry buffer. On the last digit, the stored code is written, prog=0, and the block goes to IDLE. CANCEL aborts, keeps the old code, and goes to IDLE. There is no timeout in PROG.
- LOCKOUT: all keys ignored, including CANCEL. After LOCKOUT_CYCLES cycles: lockout=0, fail_cnt=0, go to IDLE.
- fail_cnt saturates at 15.
- Timer: a single down-counter shared by UNLOCKED and LOCKOUT, sized for max(UNLOCK_CYCLES, LOCKOUT_CYCLES).
- Simultaneous key_valid with timer expiry: expiry wins and the key is dropped.
- All outputs are registered.

Optional Feature:
CODE_LOCK_CONFIRM_EN
- Defined: PROG needs the new code entered twice. The first CODE_LEN digits go to a shadow register (state PROG_CONFIRM; prog stays 1), and the second pass is compared against the shadow. On match the code is written. On mismatch the old code is kept and the block returns to IDLE with fail_cnt unchanged.
- Undefined: single-entry programming as above; no shadow register and no PROG_CONFIRM state.

Decomposition:
- Package code_lock_pkg holds:
  - state enum: IDLE, UNLOCKED, PROG, PROG_CONFIRM, LOCKOUT.
  - KEY_SET / KEY_CANCEL constants as functions of DIGIT_W.
  - helper for the timer width.
- Sub-module code_lock_timer: loadable down-counter with load/value/expired. It is instantiated once.
- Entry buffer and comparison stay in the top module.

Test Plan:
- Defaults, reset. Keys 0,0,0,0 -> unlock=1 for exactly 5 cycles starting the cycle after the 4th strobe, then 0; fail_cnt=0.
- Keys 1,0,0,0 -> no unlock; fail_cnt=1 after the 4th key only. Repeat twice more -> lockout=1 for 16 cycles. During lockout, key 0 x4 is ignored. Afterwards fail_cnt=0 and 0,0,0,0 unlocks.
- Unlock, then SET, 3,1,4,1 -> prog=1 then 0. Code 0,0,0,0 now fails and 3,1,4,1 unlocks.
- Keys 0,0 then CANCEL then 0,0,0,0 -> entry_cnt returns to 0 after CANCEL; unlock follows. A wrong entry interrupted by CANCEL leaves fail_cnt unchanged.
- rst_n low for one cycle during PROG after 2 digits -> all outputs 0 and code reverts to 0000. Also drive a key_valid strobe coincident with unlock-timer expiry -> key dropped.
- With CODE_LOCK_CONFIRM_EN defined: SET, 5,5,5,5, 5,5,5,6 -> old code retained. SET, 5,5,5,5, 5,5,5,5 -> new code 5555 active.
